spi_poll_sequencer: RTL and testbench

Autonomous controller that drives the existing SPI master (FPGA block) through a fixed transaction script.
- After reset: configures the temperature sensor (CS0) and the ADC (CS1).
- Then periodically: reads temperature integer/fraction and ADC SYSTEM_STATUS, and pushes the integer temperature to the 7-segment slave (CS2).
- Replaces manual testbench-style sequencing. Sits between the SPI master handshake ports and the user/result logic.

---
 rtl/spi_poll_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spi_poll_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_poll_sequencer.sv
// spi_poll_sequencer: runs a fixed SPI-master script (sensor/ADC init, then periodic polls) and keeps the results.
// Optional macro WATCHDOG_EN bounds each wait by TO_CYC cycles and raises a sticky err.
module seg7_dec (
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);
   always_comb begin
      case (i_nib)
         4'h0: o_seg = 7'h3F;
         4'h1: o_seg = 7'h06;
         4'h2: o_seg = 7'h5B;
         4'h3: o_seg = 7'h4F;
         4'h4: o_seg = 7'h66;
         4'h5: o_seg = 7'h6D;
         4'h6: o_seg = 7'h7D;
         4'h7: o_seg = 7'h07;
         4'h8: o_seg = 7'h7F;
         4'h9: o_seg = 7'h6F;
         4'hA: o_seg = 7'h77;
         4'hB: o_seg = 7'h7C;
         4'hC: o_seg = 7'h39;
         4'hD: o_seg = 7'h5E;
         4'hE: o_seg = 7'h79;
         default: o_seg = 7'h71;
      endcase
   end
endmodule

module spi_poll_sequencer #(
   parameter logic [7:0] TEMP_CFG = 8'hE6,
   parameter int         POLL_CYC = 1000,
   parameter int         TO_CYC   = 4096
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       enable,
   output logic [1:0] Mode,
   output logic [1:0] secondary_num,
   output logic       flag_inv,
   output logic [7:0] data_to_send,
   output logic       write_ready,
   output logic       read_ready,
   input  logic       ready_send,
   input  logic       ready_read,
   input  logic [7:0] recieved_data,
   output logic [7:0] temp_int,
   output logic [7:0] temp_frac,
   output logic [7:0] adc_status,
   output logic       round_done,
   output logic       busy,
   output logic       err
);
   localparam int         CMAX      = (POLL_CYC > TO_CYC) ? POLL_CYC : TO_CYC;
   localparam int         CW        = $clog2(CMAX + 1);
   localparam logic [3:0] INIT_END  = 4'd4;
   localparam logic [3:0] ROUND_BEG = 4'd5;
   localparam logic [3:0] ROUND_END = 4'd14;

   typedef enum logic [2:0] {INIT_S, IDLE, SETUP, STROBE, WAIT, CAPTURE, GAP} state_t;

   state_t        r_state, w_state_nx;
   logic [3:0]    r_ptr, w_ptr_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic          r_rs_q, r_rr_q, r_rs_edge, r_rr_edge;
   logic          r_err, r_done, r_busy;
   logic [7:0]    r_int, r_frac, r_adc;
   logic          w_rd, w_edge, w_timeout, w_step_done, w_act, w_last;
   logic [1:0]    w_mode, w_sec;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg;
   logic [7:0]    w_byte;

   // Script ROM: steps 0..4 are INIT, 5..14 are one poll round.
   assign w_rd   = (r_ptr == 4'd6) || (r_ptr == 4'd8) || (r_ptr == 4'd12);
   assign w_mode = (r_ptr == 4'd6 || r_ptr == 4'd8) ? 2'b11 :
                   (r_ptr < 4'd2 || r_ptr == 4'd5 || r_ptr == 4'd7) ? 2'b10 : 2'b00;
   assign w_sec  = (r_ptr >= 4'd13) ? 2'd2 :
                   ((r_ptr >= 4'd2 && r_ptr <= 4'd4) || (r_ptr >= 4'd9 && r_ptr <= 4'd12)) ? 2'd1 : 2'd0;
   assign w_nib  = (r_ptr == 4'd13) ? r_int[7:4] : r_int[3:0];

   seg7_dec u_dc (.i_nib(w_nib), .o_seg(w_seg));

   always_comb begin
      case (r_ptr)
         4'd0:        w_byte = 8'h80;
         4'd1:        w_byte = TEMP_CFG;
         4'd2:        w_byte = 8'h08;
         4'd3, 4'd5:  w_byte = 8'h02;
         4'd4:        w_byte = 8'h03;
         4'd7:        w_byte = 8'h01;
         4'd9:        w_byte = 8'h10;
         4'd13, 4'd14: w_byte = {1'b0, w_seg};
         default:     w_byte = 8'h00;
      endcase
   end

   assign w_act         = r_state inside {SETUP, STROBE, WAIT, CAPTURE};
   assign Mode          = w_act ? w_mode : 2'b00;
   assign secondary_num = w_act ? w_sec : 2'd0;
   assign flag_inv      = w_act && (w_sec != 2'd0);
   assign data_to_send  = w_act ? w_byte : 8'h00;
   assign write_ready   = (r_state == STROBE) && !w_rd;
   assign read_ready    = (r_state == STROBE) && w_rd;
   assign w_edge        = w_rd ? r_rr_edge : r_rs_edge;
   assign w_last        = (r_ptr == INIT_END) || (r_ptr == ROUND_END);

`ifdef WATCHDOG_EN
   assign w_timeout = (r_state == WAIT) && !w_edge && (r_cnt == CW'(TO_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nx  = r_state;
      w_ptr_nx    = r_ptr;
      w_cnt_nx    = r_cnt;
      w_step_done = 1'b0;
      case (r_state)
         INIT_S:  w_state_nx = SETUP;
         IDLE:    w_state_nx = enable ? SETUP : IDLE;
         SETUP: begin
            w_state_nx = STROBE;
            w_cnt_nx   = '0;
         end
         STROBE: begin
            w_state_nx = (w_rd && r_cnt == '0) ? STROBE : WAIT;
            w_cnt_nx   = (w_rd && r_cnt == '0) ? CW'(1) : '0;
         end
         WAIT: begin
            w_state_nx  = (w_edge && w_rd) ? CAPTURE : WAIT;
            w_step_done = (w_edge && !w_rd) || w_timeout;
            w_cnt_nx    = r_cnt + 1'b1;
         end
         CAPTURE: w_step_done = 1'b1;
         GAP: begin
            w_state_nx = (r_cnt != '0) ? GAP : (enable ? SETUP : IDLE);
            w_cnt_nx   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
         end
         default: w_state_nx = INIT_S;
      endcase
      if (w_step_done) begin
         w_state_nx = w_last ? GAP : SETUP;
         w_ptr_nx   = w_last ? ROUND_BEG : r_ptr + 1'b1;
         w_cnt_nx   = CW'(POLL_CYC - 1);
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state   <= INIT_S;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_rs_q    <= 1'b0;
         r_rr_q    <= 1'b0;
         r_rs_edge <= 1'b0;
         r_rr_edge <= 1'b0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_int     <= '0;
         r_frac    <= '0;
         r_adc     <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_ptr     <= w_ptr_nx;
         r_cnt     <= w_cnt_nx;
         r_rs_q    <= ready_send;
         r_rr_q    <= ready_read;
         r_rs_edge <= ready_send & ~r_rs_q;
         r_rr_edge <= ready_read & ~r_rr_q;
         r_err     <= r_err | w_timeout;
         r_done    <= w_step_done && (r_ptr == ROUND_END);
         r_busy    <= !(w_state_nx inside {IDLE, GAP});
         if (r_state == CAPTURE && r_ptr == 4'd6)  r_int  <= recieved_data;
         if (r_state == CAPTURE && r_ptr == 4'd8)  r_frac <= recieved_data;
         if (r_state == CAPTURE && r_ptr == 4'd12) r_adc  <= recieved_data;
      end
   end

   assign temp_int   = r_int;
   assign temp_frac  = r_frac;
   assign adc_status = r_adc;
   assign round_done = r_done;
   assign busy       = r_busy;
   assign err        = r_err;
endmodule

// File: tb/tb_spi_poll_sequencer.sv
// tb_spi_poll_sequencer: directed bench with an SPI-master BFM answering 20 cycles after each strobe.
module tb_spi_poll_sequencer;
   localparam int POLL = 10;

   logic       CLK = 1'b0;
   logic       Reset, enable, ready_send, ready_read, flag_inv, write_ready, read_ready;
   logic       round_done, busy, err;
   logic [1:0] Mode, secondary_num;
   logic [7:0] data_to_send, recieved_data, temp_int, temp_frac, adc_status;

   int         n_tests = 0, n_fail = 0;
   int         rd_n = 0, mute_at = -1, rr_cyc = 0, n_done = 0;
   logic [13:0] slog[$];
   logic [7:0]  rsp[$];

   spi_poll_sequencer #(.TEMP_CFG(8'hE6), .POLL_CYC(POLL), .TO_CYC(50)) dut (
      .CLK(CLK), .Reset(Reset), .enable(enable), .Mode(Mode), .secondary_num(secondary_num),
      .flag_inv(flag_inv), .data_to_send(data_to_send), .write_ready(write_ready),
      .read_ready(read_ready), .ready_send(ready_send), .ready_read(ready_read),
      .recieved_data(recieved_data), .temp_int(temp_int), .temp_frac(temp_frac),
      .adc_status(adc_status), .round_done(round_done), .busy(busy), .err(err)
   );

   always #5 CLK = ~CLK;

   function automatic logic [13:0] ent(input logic k, input logic i, input logic [1:0] s,
                                       input logic [1:0] m, input logic [7:0] d);
      return {k, i, s, m, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      step();
      while (!round_done && k < 3000) begin
         step();
         k++;
      end
      check(tag, round_done, 1);
   endtask

   task automatic wait_log(input string tag, input int n);
      int k = 0;
      while (slog.size() < n && k < 3000) begin
         step();
         k++;
      end
      check(tag, slog.size() >= n, 1);
   endtask

   task automatic wait_rd(input string tag, input int n);
      int k = 0;
      while (rd_n < n && k < 3000) begin
         step();
         k++;
      end
      check(tag, rd_n >= n, 1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 3000) begin
         step();
         k++;
      end
      check(tag, busy, 0);
   endtask

   function automatic logic [13:0] log_at(input int i);
      return (i < slog.size()) ? slog[i] : 14'h3FFF;
   endfunction

   task automatic check_round(input int base, input logic [7:0] hi, input logic [7:0] lo);
      logic [13:0] exp_r[10];
      exp_r = '{ent(0,0,0,2,8'h02), ent(1,0,0,3,8'h00), ent(0,0,0,2,8'h01), ent(1,0,0,3,8'h00),
                ent(0,1,1,0,8'h10), ent(0,1,1,0,8'h00), ent(0,1,1,0,8'h00), ent(1,1,1,0,8'h00),
                ent(0,1,2,0,hi), ent(0,1,2,0,lo)};
      for (int i = 0; i < 10; i++) check($sformatf("round@%0d step%0d", base, i), log_at(base + i), exp_r[i]);
   endtask

   // SPI master model: logs every strobe, answers each one 20 cycles later with a 2-cycle level.
   initial begin
      int s_cd = 0, s_hi = 0, r_cd = 0, r_hi = 0;
      logic rd_prev = 1'b0;
      logic [7:0] rsp_b = 8'h00;
      forever begin
         @(posedge CLK);
         #1;
         if (round_done) n_done++;
         if (read_ready) rr_cyc++;
         if (write_ready) begin
            slog.push_back({1'b0, flag_inv, secondary_num, Mode, data_to_send});
            s_cd = 20;
         end
         if (read_ready && !rd_prev) begin
            slog.push_back({1'b1, flag_inv, secondary_num, Mode, 8'h00});
            rd_n++;
            if (rd_n != mute_at && rsp.size() > 0) begin
               rsp_b = rsp.pop_front();
               r_cd = 20;
            end
         end
         rd_prev = read_ready;
         if (s_hi > 0) begin
            s_hi--;
            if (s_hi == 0) ready_send = 1'b0;
         end
         if (s_cd > 0) begin
            s_cd--;
            if (s_cd == 0) begin
               ready_send = 1'b1;
               s_hi = 2;
            end
         end
         if (r_hi > 0) begin
            r_hi--;
            if (r_hi == 0) ready_read = 1'b0;
         end
         if (r_cd > 0) begin
            r_cd--;
            if (r_cd == 0) begin
               ready_read = 1'b1;
               recieved_data = rsp_b;
               r_hi = 2;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got expired expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [13:0] init_exp[5];
      int n, base;
      init_exp = '{ent(0,0,0,2,8'h80), ent(0,0,0,2,8'hE6), ent(0,1,1,0,8'h08),
                   ent(0,1,1,0,8'h02), ent(0,1,1,0,8'h03)};
      Reset = 1'b0; enable = 1'b0; ready_send = 1'b0; ready_read = 1'b0; recieved_data = 8'h00;
      repeat (3) step();
      check("rst_mode_sec_inv", {Mode, secondary_num, flag_inv}, 0);
      check("rst_data", data_to_send, 0);
      check("rst_strobes", {write_ready, read_ready}, 0);
      check("rst_busy_done_err", {busy, round_done, err}, 0);
      check("rst_results", {temp_int, temp_frac, adc_status}, 0);

      // INIT script runs without enable, then parks.
      Reset = 1'b1;
      wait_log("init_log", 5);
      wait_idle("init_idle");
      for (int i = 0; i < 5; i++) check($sformatf("init%0d", i), log_at(i), init_exp[i]);
      repeat (POLL + 20) step();
      check("idle_no_strobe", slog.size(), 5);
      check("idle_busy", busy, 0);

      // Two rounds back to back with enable held.
      rsp = '{8'h0A, 8'h20, 8'hC8, 8'h19, 8'h33, 8'h44};
      enable = 1'b1;
      wait_done("r1_done");
      check("r1_temp_int", temp_int, 8'h0A);
      check("r1_temp_frac", temp_frac, 8'h20);
      check("r1_adc", adc_status, 8'hC8);
      check("r1_rr_cycles", rr_cyc, 6);
      check_round(5, 8'h3F, 8'h77);
      n = 0;
      while (!busy && n < 100) begin
         n++;
         step();
      end
      check("gap_cycles", n, POLL);
      wait_done("r2_done");
      check("r2_temp_int", temp_int, 8'h19);
      check("r2_temp_frac", temp_frac, 8'h33);
      check("r2_adc", adc_status, 8'h44);
      check_round(15, 8'h06, 8'h6F);

      // Drop enable during the ADC status read: round finishes, then parks.
      base = rd_n;
      rsp = '{8'h21, 8'h22, 8'h23};
      wait_rd("r3_adc_read", base + 3);
      enable = 1'b0;
      wait_done("r3_done");
      check("r3_temp_int", temp_int, 8'h21);
      check("r3_adc", adc_status, 8'h23);
      n = slog.size();
      repeat (POLL + 40) step();
      check("park_busy", busy, 0);
      check("park_no_strobe", slog.size(), n);
      check("done_pulses", n_done, 3);

      // Async reset while waiting on a read.
      rsp = '{8'h55};
      base = rd_n;
      enable = 1'b1;
      wait_rd("r4_int_read", base + 1);
      repeat (5) step();
      #1 Reset = 1'b0;
      #1;
      check("arst_read_ready", read_ready, 0);
      check("arst_mode", Mode, 0);
      check("arst_busy", busy, 0);
      check("arst_temp_int", temp_int, 0);
      enable = 1'b0;
      step();
      slog.delete();
      Reset = 1'b1;
      wait_log("reinit_log", 5);
      wait_idle("reinit_idle");
      check("reinit0", log_at(0), ent(0,0,0,2,8'h80));
      check("reinit1", log_at(1), ent(0,0,0,2,8'hE6));

`ifdef WATCHDOG_EN
      check("wd_err_clear", err, 0);
      rsp = '{8'h66, 8'h77};
      mute_at = rd_n + 2;
      enable = 1'b1;
      wait_done("wd_done");
      check("wd_err", err, 1);
      check("wd_temp_int", temp_int, 8'h66);
      check("wd_temp_frac", temp_frac, 8'h00);
      check("wd_adc", adc_status, 8'h77);
      enable = 1'b0;
`else
      check("err_tied", err, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
